// File: rtl/lvds_rx_word_aligner.sv
// Serial-to-parallel word aligner for an LVDS receive lane.
// Hunts for a sync word, verifies alignment, then emits aligned words.
module lvds_rx_word_aligner #(
    parameter int               WIDTH        = 10,
    parameter logic [WIDTH-1:0] SYNC_PATTERN = 10'b0011111010,
    parameter int               LOCK_COUNT   = 3,
    parameter int               ERR_LIMIT    = 2
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             CE,
    input  logic             DIN,
    output logic [WIDTH-1:0] DOUT,
    output logic             DOUT_VALID,
    output logic             IS_SYNC,
    output logic             LOCKED,
    output logic [3:0]       BIT_POS
);

    localparam int SW = $clog2(LOCK_COUNT + 1);
    localparam int EW = $clog2(ERR_LIMIT + 1);
    localparam logic [3:0]    LAST     = 4'(WIDTH - 1);
    localparam logic [SW-1:0] SYNC_MAX = SW'(LOCK_COUNT);
    localparam logic [EW-1:0] ERR_MAX  = EW'(ERR_LIMIT);

    typedef enum logic [1:0] {
        HUNT,
        VERIFY,
        LOCK
    } state_t;

    state_t           state, state_d;
    logic [WIDTH-2:0] sr, sr_d;
    logic [3:0]       bit_cnt, bit_d;
    logic [SW-1:0]    sync_cnt, sync_d, sync_inc;
    logic [EW-1:0]    mis_cnt, mis_d, mis_inc;
    logic [WIDTH-1:0] dout_d;
    logic             valid_d;
    logic             is_sync_d;
    logic             locked_d;
    logic [WIDTH-1:0] win;
    logic             match;
    logic             at_last;

    assign win      = {sr, DIN};
    assign match    = (win == SYNC_PATTERN);
    assign at_last  = (bit_cnt == LAST);
    assign sync_inc = (sync_cnt == SYNC_MAX) ? sync_cnt : sync_cnt + SW'(1);
    assign mis_inc  = (mis_cnt == ERR_MAX) ? mis_cnt : mis_cnt + EW'(1);
    assign BIT_POS  = bit_cnt;

    // Next-state and output decode; everything holds unless CE is high.
    always_comb begin
        state_d   = state;
        sr_d      = sr;
        bit_d     = bit_cnt;
        sync_d    = sync_cnt;
        mis_d     = mis_cnt;
        dout_d    = DOUT;
        is_sync_d = IS_SYNC;
        locked_d  = LOCKED;
        valid_d   = 1'b0;
        if (CE) begin
            sr_d  = win[WIDTH-2:0];
            bit_d = at_last ? 4'd0 : bit_cnt + 4'd1;
            unique case (state)
                HUNT: begin
                    if (match) begin
                        bit_d  = 4'd0;
                        sync_d = SW'(1);
                        if (LOCK_COUNT == 1) begin
                            state_d  = LOCK;
                            locked_d = 1'b1;
                            mis_d    = '0;
                        end else begin
                            state_d = VERIFY;
                        end
                    end
                end
                VERIFY: begin
                    if (at_last) begin
                        if (match) begin
                            sync_d = sync_inc;
                            if (sync_inc == SYNC_MAX) begin
                                state_d  = LOCK;
                                locked_d = 1'b1;
                                mis_d    = '0;
                            end
                        end else begin
                            state_d = HUNT;
                            sync_d  = '0;
                        end
                    end
                end
                LOCK: begin
                    if (at_last) begin
                        dout_d    = win;
                        is_sync_d = match;
                        valid_d   = 1'b1;
                        if (match) begin
                            mis_d = '0;
                        end
                    end else if (match) begin
                        mis_d = mis_inc;
                        if (mis_inc == ERR_MAX) begin
                            // Reuse the misaligned sync as the new anchor.
                            locked_d = 1'b0;
                            bit_d    = 4'd0;
                            sync_d   = SW'(1);
                            state_d  = VERIFY;
                            if (LOCK_COUNT == 1) begin
                                state_d  = LOCK;
                                locked_d = 1'b1;
                                mis_d    = '0;
                            end
                        end
                    end
                end
                default: begin
                    state_d = HUNT;
                end
            endcase
        end
    end

    // State, datapath and output registers with synchronous reset.
    always_ff @(posedge CLK) begin
        if (RST) begin
            state      <= HUNT;
            sr         <= '0;
            bit_cnt    <= '0;
            sync_cnt   <= '0;
            mis_cnt    <= '0;
            DOUT       <= '0;
            DOUT_VALID <= 1'b0;
            IS_SYNC    <= 1'b0;
            LOCKED     <= 1'b0;
        end else begin
            state      <= state_d;
            sr         <= sr_d;
            bit_cnt    <= bit_d;
            sync_cnt   <= sync_d;
            mis_cnt    <= mis_d;
            DOUT       <= dout_d;
            DOUT_VALID <= valid_d;
            IS_SYNC    <= is_sync_d;
            LOCKED     <= locked_d;
        end
    end

endmodule

// File: tb/tb_lvds_rx_word_aligner.sv
// Testbench for lvds_rx_word_aligner: directed scenarios plus random
// bit streams checked against a word-level reference model.
module tb_lvds_rx_word_aligner;

    localparam int         W    = 10;
    localparam int         LC   = 3;
    localparam int         EL   = 2;
    localparam logic [W-1:0] SYNC = 10'h0FA;
    localparam logic [W-1:0] ALT  = 10'h155;

    logic         CLK = 1'b0;
    logic         RST = 1'b1;
    logic         CE  = 1'b0;
    logic         DIN = 1'b0;
    logic [W-1:0] DOUT;
    logic         DOUT_VALID;
    logic         IS_SYNC;
    logic         LOCKED;
    logic [3:0]   BIT_POS;

    lvds_rx_word_aligner #(
        .WIDTH(W),
        .SYNC_PATTERN(SYNC),
        .LOCK_COUNT(LC),
        .ERR_LIMIT(EL)
    ) dut (
        .CLK(CLK),
        .RST(RST),
        .CE(CE),
        .DIN(DIN),
        .DOUT(DOUT),
        .DOUT_VALID(DOUT_VALID),
        .IS_SYNC(IS_SYNC),
        .LOCKED(LOCKED),
        .BIT_POS(BIT_POS)
    );

    always #5 CLK = ~CLK;

    int cyc = 0;
    always @(posedge CLK) cyc <= cyc + 1;

    int checks = 0;
    int errors = 0;
    int nvalid = 0;
    bit gap    = 1'b0;

    typedef struct {
        int           cyc;
        logic [W-1:0] d;
        logic         s;
    } exp_t;
    exp_t sb[$];

    // Reference model: tracks which phase of the word we are in and how
    // many aligned/misaligned syncs have been seen, in plain integers.
    int mode;      // 0 searching, 1 confirming, 2 locked
    int m_hist;    // last W-1 bits received
    int m_pos;
    int m_sync;
    int m_mis;
    bit m_locked;

    function automatic void m_step(input logic r, input logic c, input logic d);
        int  w;
        int  nxt;
        bit  hit;
        bit  bnd;
        exp_t e;
        if (r) begin
            mode = 0; m_hist = 0; m_pos = 0;
            m_sync = 0; m_mis = 0; m_locked = 0;
            return;
        end
        if (!c) return;
        w      = ((m_hist << 1) | int'(d)) & ((1 << W) - 1);
        m_hist = w & ((1 << (W - 1)) - 1);
        hit    = (w == int'(SYNC));
        bnd    = (m_pos == W - 1);
        nxt    = (m_pos + 1) % W;
        if (mode == 0) begin
            if (hit) begin
                nxt = 0; m_sync = 1;
                if (LC == 1) begin mode = 2; m_locked = 1; m_mis = 0; end
                else mode = 1;
            end
        end else if (mode == 1) begin
            if (bnd) begin
                if (hit) begin
                    m_sync = (m_sync + 1 > LC) ? LC : m_sync + 1;
                    if (m_sync == LC) begin mode = 2; m_locked = 1; m_mis = 0; end
                end else begin
                    mode = 0; m_sync = 0;
                end
            end
        end else begin
            if (bnd) begin
                e.cyc = cyc; e.d = W'(w); e.s = hit;
                sb.push_back(e);
                if (hit) m_mis = 0;
            end else if (hit) begin
                m_mis = (m_mis + 1 > EL) ? EL : m_mis + 1;
                if (m_mis == EL) begin
                    m_locked = 0; nxt = 0; m_sync = 1; mode = 1;
                    if (LC == 1) begin mode = 2; m_locked = 1; m_mis = 0; end
                end
            end
        end
        m_pos = nxt;
    endfunction

    task automatic chk(input string n, input logic [31:0] a, input logic [31:0] e);
        checks++;
        if (a !== e) begin
            errors++;
            $display("FAIL %s cyc=%0d got=%h expected=%h", n, cyc, a, e);
        end
    endtask

    task automatic step(input logic r, input logic c, input logic d);
        @(negedge CLK);
        RST = r; CE = c; DIN = d;
        @(posedge CLK);
        #1;
        m_step(r, c, d);
        chk("locked", 32'(LOCKED), 32'(m_locked));
        chk("bit_pos", 32'(BIT_POS), 32'(m_pos));
        if (r) begin
            chk("rst_dout", 32'(DOUT), 0);
            chk("rst_valid", 32'(DOUT_VALID), 0);
            chk("rst_is_sync", 32'(IS_SYNC), 0);
        end
    endtask

    task automatic send_bit(input logic b);
        if (gap) step(1'b0, 1'b0, 1'($urandom % 2));
        step(1'b0, 1'b1, b);
    endtask

    task automatic send_word(input logic [W-1:0] w);
        for (int i = W - 1; i >= 0; i--) send_bit(w[i]);
    endtask

    // Scoreboard monitor: every strobe must match the oldest expected word,
    // and no expected word may be skipped.
    always @(negedge CLK) begin
        exp_t e;
        while (sb.size() > 0 && sb[0].cyc < cyc) begin
            e = sb.pop_front();
            checks++;
            errors++;
            $display("FAIL missing_valid expected at cyc=%0d dout=%h", e.cyc, e.d);
        end
        if (DOUT_VALID === 1'b1) begin
            nvalid++;
            checks++;
            if (sb.size() == 0) begin
                errors++;
                $display("FAIL spurious_valid cyc=%0d got=%h expected=none", cyc, DOUT);
            end else begin
                e = sb.pop_front();
                if (e.cyc != cyc || DOUT !== e.d || IS_SYNC !== e.s) begin
                    errors++;
                    $display("FAIL word cyc=%0d got=%h/%b expected cyc=%0d %h/%b",
                             cyc, DOUT, IS_SYNC, e.cyc, e.d, e.s);
                end
            end
        end
    end

    task automatic acquire();
        step(1'b1, 1'b1, 1'b0);
        for (int i = 0; i < 7; i++) send_bit(1'b0);
        send_word(SYNC);
        send_word(SYNC);
        for (int i = W - 1; i >= 1; i--) send_bit(SYNC[i]);
        chk("lock_before_37", 32'(LOCKED), 0);
        send_bit(SYNC[0]);
        chk("lock_at_37", 32'(LOCKED), 1);
        send_word(ALT);
        chk("acq_dout", 32'(DOUT), 32'(ALT));
        chk("acq_is_sync", 32'(IS_SYNC), 0);
        chk("acq_valid", 32'(DOUT_VALID), 1);
        step(1'b0, 1'b0, 1'b1);
        chk("valid_one_cycle", 32'(DOUT_VALID), 0);
    endtask

    initial begin
        int nv;
        bit bits[$];
        logic r, c, d;
        logic [W-1:0] rw;

        // Reset with random data, then idle zeros.
        step(1'b1, 1'b1, 1'($urandom % 2));
        step(1'b1, 1'b1, 1'($urandom % 2));
        chk("rst_locked", 32'(LOCKED), 0);
        chk("rst_bit_pos", 32'(BIT_POS), 0);
        for (int i = 0; i < 20; i++) send_bit(1'b0);
        chk("idle_locked", 32'(LOCKED), 0);

        // Acquisition, continuous CE.
        acquire();

        // Loss of lock after a 3-bit slip.
        send_word(SYNC);
        chk("locked_sync_dout", 32'(DOUT), 32'(SYNC));
        chk("locked_sync_flag", 32'(IS_SYNC), 1);
        for (int i = 0; i < 3; i++) send_bit(1'b0);
        send_word(SYNC);
        chk("slip_first", 32'(LOCKED), 1);
        send_word(SYNC);
        chk("slip_drop", 32'(LOCKED), 0);
        send_word(SYNC);
        chk("relock_wait", 32'(LOCKED), 0);
        send_word(SYNC);
        chk("relock", 32'(LOCKED), 1);
        send_word(SYNC);
        chk("relock_dout", 32'(DOUT), 32'(SYNC));
        chk("relock_is_sync", 32'(IS_SYNC), 1);
        chk("relock_valid", 32'(DOUT_VALID), 1);

        // Reset in the middle of a word while locked.
        for (int i = W - 1; i > W - 6; i--) send_bit(ALT[i]);
        step(1'b1, 1'b1, 1'b1);
        chk("midrst_locked", 32'(LOCKED), 0);
        nv = nvalid;
        send_word(ALT);
        send_word(SYNC);
        send_word(SYNC);
        chk("midrst_two_syncs", 32'(LOCKED), 0);
        send_word(SYNC);
        chk("midrst_relock", 32'(LOCKED), 1);
        chk("midrst_no_valid", 32'(nvalid), 32'(nv));
        send_word(ALT);
        chk("midrst_first_word", 32'(DOUT), 32'(ALT));

        // Failed verify followed by normal lock.
        step(1'b1, 1'b1, 1'b0);
        nv = nvalid;
        send_word(SYNC);
        send_word(SYNC);
        send_word(ALT);
        send_word(ALT);
        chk("fail_verify_locked", 32'(LOCKED), 0);
        chk("fail_verify_valid", 32'(nvalid), 32'(nv));
        send_word(SYNC);
        send_word(SYNC);
        send_word(SYNC);
        chk("fail_verify_relock", 32'(LOCKED), 1);

        // Acquisition with CE on alternate cycles.
        gap = 1'b1;
        acquire();
        gap = 1'b0;

        // Random stream: syncs, random words and bit slips under random CE.
        step(1'b1, 1'b1, 1'b0);
        for (int n = 0; n < 5000; n++) begin
            if (bits.size() == 0) begin
                case ($urandom % 10)
                    0, 1, 2, 3, 4: rw = SYNC;
                    5, 6, 7:       rw = W'($urandom);
                    default:       rw = '0;
                endcase
                if (rw == '0) begin
                    for (int k = 0; k < 1 + int'($urandom % 3); k++)
                        bits.push_back(1'($urandom % 2));
                end else begin
                    for (int k = W - 1; k >= 0; k--) bits.push_back(rw[k]);
                end
            end
            r = ($urandom % 600) == 0;
            c = ($urandom % 4) != 0;
            if (c && !r) d = bits.pop_front();
            else d = 1'($urandom % 2);
            step(r, c, d);
        end

        for (int i = 0; i < 4; i++) step(1'b0, 1'b0, 1'b0);
        chk("scoreboard_empty", 32'(sb.size()), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
